// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and defaults for the UART transmit-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int         c_DATA_BITS = 8;
    localparam logic [3:0] c_HDR_TAG   = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Scans upward from
//               last_grant+1 with wrap and returns the first set request.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_last_grant,
    output logic [IDW-1:0]     o_next_idx,
    output logic               o_any_valid
);

    int             w_idx;
    logic [IDW-1:0] w_idx_n;

    // Walk the offsets farthest-first so the nearest requester overwrites.
    always_comb begin
        o_next_idx  = '0;
        o_any_valid = 1'b0;
        w_idx       = 0;
        w_idx_n     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx   = (int'(i_last_grant) + k) % NUM_REQ;
            w_idx_n = w_idx[IDW-1:0];
            if (i_req[w_idx_n]) begin
                o_next_idx  = w_idx_n;
                o_any_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-level round-robin arbiter feeding the UART TX FIFO.
//               Define UART_TX_ARB_HDR_EN to prefix each packet with a
//               {HDR_TAG, id} header byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         DATA_BITS = c_DATA_BITS,
    parameter int         MAX_LEN   = 16,
    parameter logic [3:0] HDR_TAG   = c_HDR_TAG
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         tx_full,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_wr,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         len_err
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_LW  = $clog2(MAX_LEN + 1);
    localparam logic [c_LW-1:0] c_LEN_LAST = c_LW'(MAX_LEN - 1);
    localparam logic [c_LW-1:0] c_LEN_ONE  = c_LW'(1);

    arb_state_t       r_state;
    logic [c_IDW-1:0] r_grant_id;
    logic [c_IDW-1:0] r_last_grant;
    logic [c_LW-1:0]  r_len_cnt;
    logic             r_len_err;

    logic [c_IDW-1:0]     w_pick;
    logic                 w_any_valid;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_accept;
    logic                 w_hdr_wr;
    logic [DATA_BITS-1:0] w_sel_data;
    logic [DATA_BITS-1:0] w_hdr_byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (c_IDW)
    ) u_rr_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_next_idx   (w_pick),
        .o_any_valid  (w_any_valid)
    );

    assign w_sel_valid = req_valid[r_grant_id];
    assign w_sel_last  = req_last[r_grant_id];
    assign w_sel_data  = req_data[int'(r_grant_id) * DATA_BITS +: DATA_BITS];

    // The write path is combinational so a full FIFO stalls in the same cycle.
    always_comb begin
        w_hdr_byte                      = '0;
        w_hdr_byte[DATA_BITS-1 -: 4]    = HDR_TAG;
        w_hdr_byte[c_IDW-1:0]           = r_grant_id;
        req_ready                       = '0;
        if (r_state == XFER && !tx_full) begin
            req_ready[r_grant_id] = 1'b1;
        end
        w_accept = (r_state == XFER) && w_sel_valid && !tx_full;
        w_hdr_wr = (r_state == HDR) && !tx_full;
        tx_wr    = w_accept | w_hdr_wr;
        tx_data  = (r_state == HDR) ? w_hdr_byte : w_sel_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= c_IDW'(NUM_REQ - 1);
            r_len_cnt    <= '0;
            r_len_err    <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_len_cnt <= '0;
                    if (w_any_valid) begin
                        r_grant_id   <= w_pick;
                        r_last_grant <= w_pick;
`ifdef UART_TX_ARB_HDR_EN
                        r_state      <= HDR;
`else
                        r_state      <= XFER;
`endif
                    end
                end
                HDR: begin
                    if (!tx_full) begin
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        if (w_sel_last) begin
                            r_state   <= IDLE;
                            r_len_cnt <= '0;
                        end else if (r_len_cnt == c_LEN_LAST) begin
                            // Forced release; the rest re-arbitrates as a new packet.
                            r_state   <= IDLE;
                            r_len_cnt <= '0;
                            r_len_err <= 1'b1;
                        end else begin
                            r_len_cnt <= r_len_cnt + c_LEN_ONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_id = r_grant_id;
    assign len_err  = r_len_err;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter (either header build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int C_BUDGET = 2000;
`ifdef UART_TX_ARB_HDR_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_full;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic [1:0]  grant_id;
    logic        busy;
    logic        len_err;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .DATA_BITS (8),
        .MAX_LEN   (16),
        .HDR_TAG   (4'hA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_full   (tx_full),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .grant_id  (grant_id),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] gid;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] src_q[NUM_REQ][$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_count = 0;
    int first_wr = 0;
    int last_wr = 0;
    int full_cycles = 0;
    int len_err_cnt = 0;
    int len_err_at_wr = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_src(input int id, input int n, input logic [7:0] base,
                            input logic [7:0] step, input bit with_last);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = base + step * 8'(k);
            src_q[id].push_back({(with_last && k == n - 1), b});
        end
    endtask

    task automatic expect_pkt(input int id, input int n, input logic [7:0] base,
                              input logic [7:0] step);
        exp_t e;
        if (HDR_N == 1) begin
            e.data = 8'hA0 | 8'(id);
            e.gid  = 2'(id);
            exp_q.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            e.data = base + step * 8'(k);
            e.gid  = 2'(id);
            exp_q.push_back(e);
        end
    endtask

    function automatic bit src_empty();
        bit r = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_drain(input bit need_idle, input string name);
        int t = 0;
        while (!(exp_q.size() == 0 && (!need_idle || (!busy && src_empty()))) && t < C_BUDGET) begin
            @(posedge clk); #2;
            t++;
        end
        check({name, "_done"}, 32'(t < C_BUDGET), 1);
    endtask

    task automatic wait_writes(input int n, input string name);
        int t = 0;
        while (wr_count < n && t < C_BUDGET) begin
            @(posedge clk); #2;
            t++;
        end
        check({name, "_reached"}, 32'(t < C_BUDGET), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
    endtask

    // Requester model: presents queue heads, retires a byte on valid&ready.
    initial begin : drv
        logic [3:0] acc;
        logic       flush;
        logic [8:0] head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc   = req_valid & req_ready;
            flush = rst;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush) src_q[i].delete();
                else if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    head             = src_q[i][0];
                    req_valid[i]     = 1'b1;
                    req_data[i*8 +: 8] = head[7:0];
                    req_last[i]      = head[8];
                end else begin
                    req_valid[i]     = 1'b0;
                    req_data[i*8 +: 8] = '0;
                    req_last[i]      = 1'b0;
                end
            end
        end
    end

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (tx_wr) begin
                    if (wr_count == 0) first_wr = cyc;
                    last_wr = cyc;
                    wr_count++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got %02h, expected no write", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(e.data));
                        check("grant_id", 32'(grant_id), 32'(e.gid));
                    end
                end
                if (tx_full) begin
                    full_cycles++;
                    check("stall_quiet", 32'({tx_wr, req_ready}), 0);
                end
                if (len_err) begin
                    len_err_cnt++;
                    len_err_at_wr = wr_count;
                end
            end
        end
    end

    initial begin : main
        rst     = 1'b1;
        tx_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_len_err", 32'(len_err), 0);
        check("rst_tx_wr", 32'(tx_wr), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Single requester, three back-to-back bytes.
        wr_count = 0;
        push_src(1, 3, 8'h11, 8'h11, 1'b1);
        expect_pkt(1, 3, 8'h11, 8'h11);
        wait_drain(1'b1, "single");
        check("single_writes", 32'(wr_count), 32'(3 + HDR_N));
        check("single_b2b", 32'(last_wr - first_wr), 32'(2 + HDR_N));
        check("single_idle", 32'(busy), 0);

        // Fairness: all requesters with two 2-byte packets each.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NUM_REQ; i++)
                push_src(i, 2, 8'(8'h40 + i * 16 + p * 2), 8'h01, 1'b1);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NUM_REQ; i++)
                expect_pkt(i, 2, 8'(8'h40 + i * 16 + p * 2), 8'h01);
        wait_drain(1'b1, "fair");

        // Back-pressure for five cycles mid-packet.
        wr_count    = 0;
        full_cycles = 0;
        push_src(3, 6, 8'h60, 8'h01, 1'b1);
        expect_pkt(3, 6, 8'h60, 8'h01);
        wait_writes(2 + HDR_N, "bp");
        tx_full = 1'b1;
        repeat (5) begin @(posedge clk); #2; end
        tx_full = 1'b0;
        wait_drain(1'b1, "bp");
        check("bp_full_cycles", 32'(full_cycles), 5);
        check("bp_writes", 32'(wr_count), 32'(6 + HDR_N));

        // Truncation: 20 bytes without a last marker.
        wr_count    = 0;
        len_err_cnt = 0;
        push_src(2, 20, 8'h80, 8'h01, 1'b0);
        expect_pkt(2, 16, 8'h80, 8'h01);
        expect_pkt(2, 4, 8'h90, 8'h01);
        wait_drain(1'b0, "trunc");
        repeat (3) begin @(posedge clk); #2; end
        check("trunc_len_err_cnt", 32'(len_err_cnt), 1);
        check("trunc_len_err_pos", 32'(len_err_at_wr), 32'(16 + HDR_N));
        check("trunc_hold_busy", 32'(busy), 1);
        check("trunc_hold_grant", 32'(grant_id), 2);

        // Reset after the second of five bytes.
        do_reset();
        wr_count = 0;
        push_src(1, 5, 8'hC1, 8'h01, 1'b1);
        expect_pkt(1, 2, 8'hC1, 8'h01);
        wait_writes(2 + HDR_N, "mid_rst");
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_tx_wr", 32'(tx_wr), 0);
        check("mrst_req_ready", 32'(req_ready), 0);
        check("mrst_grant_id", 32'(grant_id), 0);
        check("mrst_writes", 32'(wr_count), 32'(2 + HDR_N));
        push_src(1, 2, 8'hE0, 8'h01, 1'b1);
        push_src(0, 2, 8'hD0, 8'h01, 1'b1);
        expect_pkt(0, 2, 8'hD0, 8'h01);
        expect_pkt(1, 2, 8'hE0, 8'h01);
        wait_drain(1'b1, "post_rst");

        // Last marker on the MAX_LEN-th byte is a normal end.
        len_err_cnt = 0;
        push_src(2, 16, 8'h20, 8'h01, 1'b1);
        expect_pkt(2, 16, 8'h20, 8'h01);
        wait_drain(1'b1, "exact_max");
        repeat (2) begin @(posedge clk); #2; end
        check("exact_max_no_len_err", 32'(len_err_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares the single UART transmit path among NUM_REQ byte-stream requesters. It sits directly in front of the UART core's TX FIFO write port (data_in / pulse_tx, back-pressured by tx_full). It grants one requester at a time for a whole packet, never interleaving bytes of different packets. A packet is delimited by req_last or by the MAX_LEN limit.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_BITS, 8: byte width, matches the UART core
- MAX_LEN, 16: maximum bytes per packet before forced release (≥2)
- HDR_TAG, 4'hA: upper nibble of the header byte (header build only)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_BITS  per-requester byte; requester i occupies bits [i*DATA_BITS +: DATA_BITS]
- req_last  in  NUM_REQ  marks the final byte of a packet
- req_ready  out  NUM_REQ  byte accepted when valid&ready are both high on a rising edge
- tx_full  in  1  TX FIFO full, from the UART core
- tx_data  out  DATA_BITS  byte to the TX FIFO (core data_in)
- tx_wr  out  1  one-cycle write strobe to the TX FIFO (core pulse_tx)
- grant_id  out  clog2(NUM_REQ)  currently granted requester
- busy  out  1  high while not in IDLE
- len_err  out  1  one-cycle pulse on a MAX_LEN truncation

## Operation
- FSM states are IDLE, HDR and XFER. HDR exists only with the header build.
- IDLE:
  - If any req_valid is high, select the first valid index scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register it into grant_id and last_grant.
  - Go to HDR if the header build is compiled in, else to XFER.
  - If no req_valid is high, stay in IDLE.
- HDR:
  - tx_data = {HDR_TAG, grant_id zero-extended to DATA_BITS-4}.
  - tx_wr = !tx_full.
  - On a write, go to XFER. While tx_full is high, hold in HDR.
- XFER:
  - req_ready[g] = !tx_full for the granted index g. All other req_ready are 0.
  - tx_wr = req_valid[g] & !tx_full, and tx_data = req_data[g]. Both are combinational.
  - Each accepted byte increments len_cnt (width clog2(MAX_LEN+1)). len_cnt clears on entry to IDLE.
  - If an accepted byte has req_last=1, go to IDLE.
  - Else, if the accepted byte is the MAX_LEN-th (len_cnt==MAX_LEN-1 before the increment): go to IDLE and pulse len_err. The requester's remaining bytes then arbitrate again as a new packet.
  - If req_valid[g] drops mid-packet, hold the grant indefinitely (no timeout).
- Outside XFER, req_ready is all-zero. tx_wr is 0 in IDLE.
- Simultaneous events:
  - req_last on the MAX_LEN-th byte is a normal end; no len_err.
  - A requester that just released competes in the next IDLE at the lowest priority.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM_REQ-1 (so requester 0 wins first), grant_id = 0, len_cnt = 0.
  - busy = 0, len_err = 0, tx_wr = 0, req_ready = 0.
- Reset mid-packet aborts immediately. Bytes already written stay in the FIFO; the FIFO has its own reset.
- Arbitration latency: request seen in IDLE at cycle n → first header or data write at cycle n+1 at the earliest.
- Throughput: one byte per cycle while tx_full is low.
- Packet turnaround: one IDLE cycle between packets (two with the header, counting HDR).
- Back-pressure: tx_full high stalls with zero writes that cycle. No byte is lost or duplicated.

## Configuration
- Macro: UART_TX_ARB_HDR_EN.
- Defined: HDR state present. Every packet is prefixed with one header byte {HDR_TAG, id}. The header does not count toward MAX_LEN.
- Undefined: no HDR state, IDLE goes straight to XFER, and HDR_TAG is unused. The wire stream is the concatenation of raw packets.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum typedef (IDLE/HDR/XFER);
  - the DATA_BITS default;
  - the HDR_TAG default.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the req vector and last_grant; outputs are the next index and any_valid.

## Test plan
- Single requester: requester 1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) with tx_full=0 → tx_wr high 3 consecutive cycles with those bytes, grant_id=1, then back to IDLE. With the header build, 0xA1 precedes the data.
- Fairness: all 4 requesters continuously send 2-byte packets → grant order 0,1,2,3,0,… and no interleaving within a packet.
- Back-pressure: tx_full forced high for 5 cycles mid-packet → tx_wr=0 and req_ready=0 for exactly those cycles, and byte order is preserved.
- Truncation: requester 2 sends 20 bytes with no req_last, MAX_LEN=16 →
  - bytes 1-16 are written, then len_err pulses once;
  - bytes 17-20 follow as a new packet after re-arbitration (a new header with the header build).
- Reset mid-packet: rst asserted after the 2nd of 5 bytes → next cycle state=IDLE, all outputs zero. After release, requester 0 gets the first grant.
